uart_seg_test: RTL and testbench



---
 rtl/uart_seg_test.sv | 196 +++++++++++++++++++
 tb/tb_uart_seg_test.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_seg_test.sv
// UART frame receiver (FF FF D3 D2 D1 D0) feeding an 8-digit multiplexed
// common-anode hex display; the last received 32-bit value stays shown.
module uart_seg_test #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int SCAN_CNT = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  sel,
  output logic [7:0]  seg,
  output logic [31:0] data_out,
  output logic        data_valid
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(BIT_CNT + 1);
  localparam int SCAN_W  = $clog2(SCAN_CNT + 1);

  localparam logic [CNT_W-1:0]  HALF_BIT  = CNT_W'(BIT_CNT / 2);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BIT_CNT - 1);
  localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(SCAN_CNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [2:0] P_H0 = 3'd0;
  localparam logic [2:0] P_H1 = 3'd1;
  localparam logic [2:0] P_D3 = 3'd2;
  localparam logic [2:0] P_D2 = 3'd3;
  localparam logic [2:0] P_D1 = 3'd4;
  localparam logic [2:0] P_D0 = 3'd5;

  function automatic logic [7:0] hex7(input logic [3:0] nib);
    hex7 = 8'hFF;
    case (nib)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      4'hF: hex7 = 8'h8E;
      default: hex7 = 8'hFF;
    endcase
  endfunction

  logic             rx_p0, rx_p1, rx_p2;
  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_valid;

  logic [2:0]       pstate;
  logic [23:0]      frame_p;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit;

  // Stage p0/p1: synchronizer; p2 holds the previous level for edge detect.
  // All three reset high so a line held low at reset release reads as a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Receiver control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_p2 && !rx_p1) begin
            state   <= S_START;
            bit_cnt <= '0;
          end
        end
        S_START: begin
          if (bit_cnt == HALF_BIT) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_p1 ? S_IDLE : S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a start edge right at its end is not missed.
          if (bit_cnt == LAST_BIT) begin
            bit_cnt    <= '0;
            state      <= S_IDLE;
            byte_valid <= rx_p1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && bit_cnt == LAST_BIT) shreg <= {rx_p1, shreg[7:1]};
  end

  // Frame parser control; data bytes are never header-checked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pstate     <= P_H0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (byte_valid) begin
        case (pstate)
          P_H0: if (shreg == 8'hFF) pstate <= P_H1;
          P_H1: pstate <= (shreg == 8'hFF) ? P_D3 : P_H0;
          P_D3: pstate <= P_D2;
          P_D2: pstate <= P_D1;
          P_D1: pstate <= P_D0;
          P_D0: begin
            data_out   <= {frame_p, shreg};
            data_valid <= 1'b1;
            pstate     <= P_H0;
          end
          default: pstate <= P_H0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) begin
      case (pstate)
        P_D3: frame_p[23:16] <= shreg;
        P_D2: frame_p[15:8]  <= shreg;
        P_D1: frame_p[7:0]   <= shreg;
        default: ;
      endcase
    end
  end

  // Display scan; seg and sel are registered from the same digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= '0;
      sel      <= 8'hFE;
      seg      <= 8'hC0;
    end else begin
      if (scan_cnt == LAST_SCAN) begin
        scan_cnt <= '0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      sel <= ~(8'd1 << digit);
      seg <= hex7(data_out[{digit, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_uart_seg_test.sv
// Bench for uart_seg_test: serial byte driver, frame-level reference model,
// and display scan checks.
`timescale 1ns/1ps
module tb_uart_seg_test;

  localparam int CLK_HZ = 3_686_400;
  localparam int BAUD   = 115_200;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int SCAN   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [7:0]  sel;
  logic [7:0]  seg;
  logic [31:0] data_out;
  logic        data_valid;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  rxq[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_seg_test #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD), .SCAN_CNT(SCAN)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .sel(sel), .seg(seg),
    .data_out(data_out), .data_valid(data_valid)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1 && data_valid === 1'b1) got_q.push_back(data_out);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit, pulses=%0d", got_q.size());
    $fatal(1, "time limit");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial 8N1 driver; a byte with a good stop bit is logged for the model.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    int g;
    g = (!stop && gap < 1) ? 1 : gap;
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BIT);
    end
    rx = stop;
    cyc(BIT);
    rx = 1'b1;
    cyc(g * BIT);
    if (stop) rxq.push_back(b);
  endtask

  task automatic send_frame(input logic [31:0] v, input int gap);
    send_byte(8'hFF, 1'b1, gap);
    send_byte(8'hFF, 1'b1, gap);
    send_byte(v[31:24], 1'b1, gap);
    send_byte(v[23:16], 1'b1, gap);
    send_byte(v[15:8], 1'b1, gap);
    send_byte(v[7:0], 1'b1, gap);
  endtask

  // Frame extraction over the whole received byte stream.
  task automatic model_frames();
    int i;
    exp_q.delete();
    i = 0;
    while (i + 5 < rxq.size()) begin
      if (rxq[i] == 8'hFF && rxq[i+1] == 8'hFF) begin
        exp_q.push_back({rxq[i+2], rxq[i+3], rxq[i+4], rxq[i+5]});
        i += 6;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b0;
    #12;
    nvec++; if (data_out !== 32'h0) begin nerr++; $display("FAIL reset_data_out: got %h want 00000000", data_out); end
    nvec++; if (data_valid !== 1'b0) begin nerr++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    nvec++; if (sel !== 8'hFE) begin nerr++; $display("FAIL reset_sel: got %h want fe", sel); end
    nvec++; if (seg !== 8'hC0) begin nerr++; $display("FAIL reset_seg: got %h want c0", seg); end
    #8 rst_n = 1'b1;
    cyc(4);
    rx = 1'b1;
    cyc(3 * BIT);
    nvec++; if (got_q.size() != 0 || data_out !== 32'h0) begin
      nerr++; $display("FAIL reset_low_rx_glitch: got %0d pulses data %h want 0 pulses data 00000000", got_q.size(), data_out);
    end
  endtask

  task automatic test_first_frame();
    int base;
    base = got_q.size();
    send_frame(32'h2523512F, 0);
    cyc(4);
    nvec++; if (got_q.size() - base != 1) begin nerr++; $display("FAIL first_frame_pulses: got %0d want 1", got_q.size() - base); end
    nvec++; if (data_out !== 32'h2523512F) begin nerr++; $display("FAIL first_frame_data: got %h want 2523512f", data_out); end
  endtask

  task automatic test_scan();
    logic [7:0] want [8];
    logic [7:0] pat;
    int t;
    want = '{8'h8E, 8'hA4, 8'hF9, 8'h92, 8'hB0, 8'hA4, 8'h92, 8'hA4};
    for (int k = 0; k < 8; k++) begin
      pat = ~(8'd1 << k);
      t = 0;
      @(negedge clk);
      while (sel !== pat && t < 8 * SCAN + 8) begin
        @(negedge clk);
        t++;
      end
      nvec++;
      if (sel !== pat) begin
        nerr++; $display("FAIL scan_sel_%0d: got %h want %h (timeout)", k, sel, pat);
      end else if (seg !== want[k]) begin
        nerr++; $display("FAIL scan_seg_%0d: got %h want %h", k, seg, want[k]);
      end
    end
  endtask

  task automatic test_header_resync();
    logic [7:0] bs [8];
    int base;
    bs = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};
    base = got_q.size();
    for (int i = 0; i < 8; i++) send_byte(bs[i], 1'b1, 1);
    cyc(4);
    nvec++; if (got_q.size() - base != 1) begin nerr++; $display("FAIL resync_pulses: got %0d want 1", got_q.size() - base); end
    nvec++; if (data_out !== 32'h12345678) begin nerr++; $display("FAIL resync_data: got %h want 12345678", data_out); end
  endtask

  task automatic test_all_ff();
    int base;
    base = got_q.size();
    for (int i = 0; i < 6; i++) send_byte(8'hFF, 1'b1, 0);
    cyc(4);
    nvec++; if (got_q.size() - base != 1) begin nerr++; $display("FAIL all_ff_pulses: got %0d want 1", got_q.size() - base); end
    nvec++; if (data_out !== 32'hFFFFFFFF) begin nerr++; $display("FAIL all_ff_data: got %h want ffffffff", data_out); end
  endtask

  task automatic test_framing_error();
    int base;
    base = got_q.size();
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'hAA, 1'b1, 1);
    send_byte(8'hBB, 1'b1, 1);
    send_byte(8'hCC, 1'b0, 1);
    send_byte(8'hDD, 1'b1, 1);
    cyc(4);
    nvec++; if (got_q.size() - base != 0) begin nerr++; $display("FAIL framing_no_pulse: got %0d want 0", got_q.size() - base); end
    send_byte(8'hEE, 1'b1, 1);
    cyc(4);
    nvec++; if (got_q.size() - base != 1) begin nerr++; $display("FAIL framing_pulses: got %0d want 1", got_q.size() - base); end
    nvec++; if (data_out !== 32'hAABBDDEE) begin nerr++; $display("FAIL framing_data: got %h want aabbddee", data_out); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    int base;
    b = 8'h5A;
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h02, 1'b1, 1);
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      cyc(BIT);
    end
    rst_n = 1'b0;
    cyc(1);
    nvec++; if (data_out !== 32'h0) begin nerr++; $display("FAIL midreset_data: got %h want 00000000", data_out); end
    nvec++; if (sel !== 8'hFE || seg !== 8'hC0) begin nerr++; $display("FAIL midreset_display: got sel %h seg %h want fe c0", sel, seg); end
    rst_n = 1'b1;
    rx    = 1'b1;
    rxq.delete();
    cyc(2 * BIT);
    base = got_q.size();
    nvec++; if (data_out !== 32'h0) begin nerr++; $display("FAIL midreset_hold: got %h want 00000000", data_out); end
    send_frame(32'h9ABCDEF0, 1);
    cyc(4);
    nvec++; if (got_q.size() - base != 1) begin nerr++; $display("FAIL midreset_pulses: got %0d want 1", got_q.size() - base); end
    nvec++; if (data_out !== 32'h9ABCDEF0) begin nerr++; $display("FAIL midreset_data_new: got %h want 9abcdef0", data_out); end
  endtask

  task automatic test_back_to_back();
    int n;
    rxq.delete();
    got_q.delete();
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(2);
      for (int j = 0; j < n; j++)
        send_byte(8'($urandom), ($urandom_range(7) != 0), $urandom_range(1));
      send_byte(8'hFF, 1'b1, $urandom_range(1));
      send_byte(8'hFF, 1'b1, $urandom_range(1));
      for (int j = 0; j < 4; j++)
        send_byte(8'($urandom), ($urandom_range(9) != 0), $urandom_range(1));
    end
    cyc(4);
    model_frames();
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL random_pulses: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL random_frame_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (exp_q.size() > 0) begin
      nvec++; if (data_out !== exp_q[exp_q.size()-1]) begin nerr++; $display("FAIL random_last: got %h want %h", data_out, exp_q[exp_q.size()-1]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_scan();
    test_header_resync();
    test_all_ff();
    test_framing_error();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
